// File: rtl/ws_operand_loader_pkg.sv
// Shared types and defaults for the weighted-sum operand loader.
// Holds the FSM state encoding, default sizes and a counter-width helper.
package ws_pkg;

   localparam int WS_DEFAULT_WIDTH       = 16;
   localparam int WS_DEFAULT_INPUT_SIZE  = 10;
   localparam int WS_DEFAULT_SUM_LATENCY = 1;

   typedef logic [WS_DEFAULT_WIDTH-1:0] ws_word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } ws_ld_state_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int ws_cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ws_operand_loader_if.sv
// Operand stream, weighted-sum vector and result port of the operand loader.
// Both streams use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; valid, once high, holds its payload stable
// until that edge, and ready may change freely.
interface ws_operand_loader_if #(
   parameter int INPUT_SIZE = 10,
   parameter int WIDTH      = 16
);

   logic                        in_valid;
   logic                        in_ready;
   logic [WIDTH-1:0]            in_data;
   logic [WIDTH-1:0]            in_weight;
   logic                        in_last;
   logic [INPUT_SIZE*WIDTH-1:0] vec_inputs;
   logic [INPUT_SIZE*WIDTH-1:0] vec_weights;
   logic                        vec_valid;
   logic [WIDTH-1:0]            ws_sum;
   logic                        res_valid;
   logic                        res_ready;
   logic [WIDTH-1:0]            res_sum;
   logic                        res_err;

   modport master (
      input  in_valid, in_data, in_weight, in_last, ws_sum, res_ready,
      output in_ready, vec_inputs, vec_weights, vec_valid,
             res_valid, res_sum, res_err
   );

   modport slave (
      output in_valid, in_data, in_weight, in_last, ws_sum, res_ready,
      input  in_ready, vec_inputs, vec_weights, vec_valid,
             res_valid, res_sum, res_err
   );

endinterface

// File: rtl/ws_operand_loader_bank.sv
// N x W operand register file: one indexed write port, synchronous clear,
// and the whole bank presented as a flat vector (slot i at [i*W +: W]).
module ws_operand_bank #(
   parameter int N  = 10,
   parameter int W  = 16,
   parameter int IW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  logic [IW-1:0]  wr_idx,
   input  logic [W-1:0]   wr_data,
   input  logic           clr,
   output logic [N*W-1:0] rd_vec
);

   logic [W-1:0] mem_q [N];
   logic [W-1:0] mem_d [N];

   // Clear wins over write; an index past the last slot writes nothing.
   always_comb begin
      mem_d = mem_q;
      if (clr) begin
         for (int i = 0; i < N; i++) mem_d[i] = '0;
      end else if (wr_en) begin
         for (int i = 0; i < N; i++) begin
            if (wr_idx == IW'(i)) mem_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      rd_vec = '0;
      for (int i = 0; i < N; i++) rd_vec[i*W +: W] = mem_q[i];
   end

endmodule

// File: rtl/ws_operand_loader.sv
// Collects (input, weight) beats into operand vectors, holds them for the
// weighted-sum stage, samples the returned sum and offers it as a result.
module ws_operand_loader
   import ws_pkg::*;
#(
   parameter int INPUT_SIZE  = WS_DEFAULT_INPUT_SIZE,
   parameter int WIDTH       = WS_DEFAULT_WIDTH,
   parameter int SUM_LATENCY = WS_DEFAULT_SUM_LATENCY
) (
   input  logic                clk,
   input  logic                rst_n,
   ws_operand_loader_if.master bus,
   output ws_ld_state_t        state_o
);

   localparam int IDX_W = ws_cnt_width(INPUT_SIZE);
   localparam int LAT_W = ws_cnt_width(SUM_LATENCY - 1);

   ws_ld_state_t     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] res_sum_q, res_sum_d;
   logic             res_err_q, res_err_d;
   logic             in_ready_q, in_ready_d;
   logic             vec_valid_q, vec_valid_d;
   logic             res_valid_q, res_valid_d;
   logic             wr_en;
   logic             bank_clr;
   logic             last_slot;

   assign last_slot = (idx_q == IDX_W'(INPUT_SIZE - 1));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lat_d     = lat_q;
      err_d     = err_q;
      res_sum_d = res_sum_q;
      res_err_d = res_err_q;
      wr_en     = 1'b0;
      bank_clr  = 1'b0;
      case (state_q)
         IDLE: state_d = LOAD;
         LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               wr_en = 1'b1;
               idx_d = idx_q + 1'b1;
               // in_last must coincide with the final slot; either side alone
               // (short or long vector) marks the vector as bad.
               err_d = err_q | (bus.in_last != last_slot);
               if (bus.in_last || last_slot) begin
                  state_d = WAIT;
                  lat_d   = LAT_W'(SUM_LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (lat_q == '0) begin
               res_sum_d = bus.ws_sum;
               res_err_d = err_q;
               state_d   = RESULT;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         RESULT: begin
            if (bus.res_ready) begin
               bank_clr = 1'b1;
               idx_d    = '0;
               err_d    = 1'b0;
               state_d  = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == LOAD);
      vec_valid_d = (state_d == WAIT) || (state_d == RESULT);
      res_valid_d = (state_d == RESULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         lat_q       <= '0;
         err_q       <= 1'b0;
         res_sum_q   <= '0;
         res_err_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         vec_valid_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lat_q       <= lat_d;
         err_q       <= err_d;
         res_sum_q   <= res_sum_d;
         res_err_q   <= res_err_d;
         in_ready_q  <= in_ready_d;
         vec_valid_q <= vec_valid_d;
         res_valid_q <= res_valid_d;
      end
   end

   ws_operand_bank #(.N(INPUT_SIZE), .W(WIDTH), .IW(IDX_W)) u_input_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (bus.in_data),
      .clr     (bank_clr),
      .rd_vec  (bus.vec_inputs)
   );

   ws_operand_bank #(.N(INPUT_SIZE), .W(WIDTH), .IW(IDX_W)) u_weight_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (bus.in_weight),
      .clr     (bank_clr),
      .rd_vec  (bus.vec_weights)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.vec_valid = vec_valid_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_sum   = res_sum_q;
   assign bus.res_err   = res_err_q;
   assign state_o       = state_q;

endmodule
